rc5_round_scheduler: RTL
========================

// Module: rc5_round_scheduler
// PURPOSE
//  Sequences one shared, iterative RC5-32 round core so that one block serves both encrypt and decrypt.
//  - Arbitrates between an encrypt requester and a decrypt requester (valid/ready, round-robin).
//  - Owns the A/B working registers and the pre-round add / post-round subtract.
//  - Addresses the expanded-key table and returns {A,B} on a valid/ready output port.
//  - The external round core is combinational: rnd_*_nxt = one round of rnd_a/rnd_b under key_lo/key_hi.
// PARAMETERS
//  W       32  word width; 64-bit block = {A,B}
//  ROUNDS  12  round count; the key table holds 2*ROUNDS+2 words
//  KW       5  key_idx width; must satisfy 2^KW >= 2*ROUNDS+2
// PORTS
//  clk        in   1     single clock, rising edge
//  clr        in   1     reset: asynchronous, active-low
//  enc_vld    in   1     encrypt request valid
//  enc_din    in   2W    plaintext {A,B}
//  enc_rdy    out  1     encrypt request accepted when enc_vld & enc_rdy
//  dec_vld    in   1     decrypt request valid
//  dec_din    in   2W    ciphertext {A,B}
//  dec_rdy    out  1     decrypt request accepted when dec_vld & dec_rdy
//  key_idx    out  KW    key table address; key_lo = S[key_idx], key_hi = S[key_idx+1]
//  key_lo     in   W     S[key_idx], combinational return
//  key_hi     in   W     S[key_idx+1], combinational return
//  rnd_mode   out  1     0 = encrypt round, 1 = decrypt round
//  rnd_a      out  W     current A register
//  rnd_b      out  W     current B register
//  rnd_a_nxt  in   W     round-core result for A
//  rnd_b_nxt  in   W     round-core result for B
//  out_vld    out  1     result valid
//  out_dir    out  1     direction of the result (0 = enc, 1 = dec)
//  out_data   out  2W    result {A,B}
//  out_rdy    in   1     downstream accepts the result
// BEHAVIOUR
//  Reset (clr=0, asynchronous)
//   - State=IDLE; A, B, rcnt, mode, key_idx, out_vld and out_dir all go to 0; last_grant=DEC.
//   - enc_rdy and dec_rdy are forced 0 while clr=0.
//   - Reset mid-operation abandons the block silently; no out_vld follows.
//  States: IDLE -> PRE -> ROUND (ROUNDS cycles) -> POST -> HOLD -> IDLE.
//  IDLE
//   - enc_rdy = !dec_vld | (last_grant==DEC).
//   - dec_rdy = !enc_vld | (last_grant==ENC).
//   - Both ready outputs are 0 in every state other than IDLE.
//   - On acceptance: {A,B}<=din, mode<=dir, last_grant<=dir, go to PRE.
//  PRE (1 cycle), key_idx=0
//   - enc: A<=A+key_lo, B<=B+key_hi.
//   - dec: A and B hold.
//   - rcnt<=1 (enc) or ROUNDS (dec).
//  ROUND (1 cycle per round)
//   - key_idx = 2*rcnt; A<=rnd_a_nxt, B<=rnd_b_nxt.
//   - enc: rcnt increments; after the round at rcnt==ROUNDS go to POST.
//   - dec: rcnt decrements; after the round at rcnt==1 go to POST.
//  POST (1 cycle), key_idx=0
//   - dec: A<=A-key_lo, B<=B-key_hi.
//   - enc: A and B hold.
//   - Go to HOLD.
//  HOLD
//   - out_vld=1; out_data={A,B} and out_dir=mode stay stable until out_vld & out_rdy.
//   - On that handshake go to IDLE, and out_vld drops next cycle.
//  key_idx = 0 in IDLE and HOLD.
//  Latency: out_vld rises ROUNDS+2 cycles after the accepting edge (14 with the default ROUNDS).
//  Throughput: at most one request per ROUNDS+4 cycles.
//  Arithmetic is modulo 2^W; there is no overflow signalling.
// TESTING (bench key table S[k]=k; round core is pass-through: rnd_*_nxt = rnd_*)
//  1. Reset test
//   - Assert clr=0 mid-cycle -> out_vld=0 and key_idx=0 immediately.
//   - Release clr with no requests -> enc_rdy=1 and dec_rdy=1.
//  2. Encrypt test
//   - enc_din=64'h00000010_00000020 -> out_data=64'h00000010_00000021, out_dir=0.
//   - out_vld rises exactly 14 cycles after the accepting edge.
//   - key_idx sequence: 0,2,4,...,24,0.
//  3. Decrypt test
//   - dec_din=64'h00000010_00000021 -> out_data=64'h00000010_00000020, out_dir=1.
//   - key_idx sequence: 0,24,22,...,2,0.
//  4. Arbitration test
//   - After reset, enc_vld and dec_vld are both held high for three requests each.
//   - Required grant order: ENC, DEC, ENC, DEC, ENC, DEC.
//   - No grant occurs outside IDLE.
//  5. Backpressure test
//   - out_rdy is held low for 5 cycles in HOLD.
//   - out_vld, out_data and out_dir stay stable; both ready outputs stay 0.
//   - Release out_rdy -> next request accepted one cycle after the handshake.
//  6. Mid-operation reset test
//   - Assert clr=0 during ROUND with rcnt=6 -> all outputs return to reset values asynchronously.
//   - No out_vld follows; a fresh encrypt after release matches test 2.

Source files
------------

// File: rtl/rc5_round_scheduler.sv
// RC5-32 round scheduler: arbitrates encrypt/decrypt requests onto one shared
// combinational round core, owns the A/B working registers, applies the
// pre-round key add (encrypt) or post-round key subtract (decrypt), drives the
// expanded-key table address and presents the result on a valid/ready port.
module rc5_round_scheduler #(
    parameter int W      = 32,
    parameter int ROUNDS = 12,
    parameter int KW     = 5
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            enc_vld,
    input  logic [2*W-1:0]  enc_din,
    output logic            enc_rdy,
    input  logic            dec_vld,
    input  logic [2*W-1:0]  dec_din,
    output logic            dec_rdy,
    output logic [KW-1:0]   key_idx,
    input  logic [W-1:0]    key_lo,
    input  logic [W-1:0]    key_hi,
    output logic            rnd_mode,
    output logic [W-1:0]    rnd_a,
    output logic [W-1:0]    rnd_b,
    input  logic [W-1:0]    rnd_a_nxt,
    input  logic [W-1:0]    rnd_b_nxt,
    output logic            out_vld,
    output logic            out_dir,
    output logic [2*W-1:0]  out_data,
    input  logic            out_rdy
);

    localparam int CW = $clog2(ROUNDS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ROUND,
        S_POST,
        S_HOLD
    } state_t;

    typedef enum logic {
        DIR_ENC = 1'b0,
        DIR_DEC = 1'b1
    } dir_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [CW-1:0]  rcnt_q, rcnt_d;
    dir_t           mode_q, mode_d;
    dir_t           lg_q, lg_d;

    assign rnd_mode = mode_q;
    assign rnd_a    = a_q;
    assign rnd_b    = b_q;
    assign out_dir  = mode_q;
    assign out_data = {a_q, b_q};

    // State and datapath registers; reset abandons any block in flight.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            rcnt_q  <= '0;
            mode_q  <= DIR_ENC;
            lg_q    <= DIR_DEC;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rcnt_q  <= rcnt_d;
            mode_q  <= mode_d;
            lg_q    <= lg_d;
        end
    end

    // Next-state, datapath update, key addressing and handshake outputs.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        rcnt_d  = rcnt_q;
        mode_d  = mode_q;
        lg_d    = lg_q;
        enc_rdy = 1'b0;
        dec_rdy = 1'b0;
        key_idx = '0;
        out_vld = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Round-robin: a contended request goes to the side not granted last.
                enc_rdy = clr & (~dec_vld | (lg_q == DIR_DEC));
                dec_rdy = clr & (~enc_vld | (lg_q == DIR_ENC));
                if (enc_vld && enc_rdy) begin
                    {a_d, b_d} = enc_din;
                    mode_d     = DIR_ENC;
                    lg_d       = DIR_ENC;
                    state_d    = S_PRE;
                end else if (dec_vld && dec_rdy) begin
                    {a_d, b_d} = dec_din;
                    mode_d     = DIR_DEC;
                    lg_d       = DIR_DEC;
                    state_d    = S_PRE;
                end
            end
            S_PRE: begin
                if (mode_q == DIR_ENC) begin
                    a_d    = a_q + key_lo;
                    b_d    = b_q + key_hi;
                    rcnt_d = CW'(1);
                end else begin
                    rcnt_d = CW'(ROUNDS);
                end
                state_d = S_ROUND;
            end
            S_ROUND: begin
                key_idx = KW'(rcnt_q) << 1;
                a_d     = rnd_a_nxt;
                b_d     = rnd_b_nxt;
                if (mode_q == DIR_ENC) begin
                    rcnt_d = rcnt_q + CW'(1);
                    if (rcnt_q == CW'(ROUNDS)) state_d = S_POST;
                end else begin
                    rcnt_d = rcnt_q - CW'(1);
                    if (rcnt_q == CW'(1)) state_d = S_POST;
                end
            end
            S_POST: begin
                if (mode_q == DIR_DEC) begin
                    a_d = a_q - key_lo;
                    b_d = b_q - key_hi;
                end
                state_d = S_HOLD;
            end
            S_HOLD: begin
                out_vld = 1'b1;
                if (out_rdy) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
